// File: rtl/median_ctrl.sv
// median_ctrl: sequencing controller for the MED median datapath.
// Counts a pixel burst, runs the load/sort passes, flags the median.
module median_ctrl #(
   parameter int NB_PIXEL = 9
) (
   input  logic CLK,
   input  logic nRST,
   input  logic DSI,
   output logic MED_DSI,
   output logic MED_BYP,
   output logic DSO,
   output logic BUSY,
   output logic ERR
);

   localparam int P  = (NB_PIXEL - 1) / 2;
   localparam int CW = $clog2(NB_PIXEL);

   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(NB_PIXEL - 1);
   localparam logic [CW-1:0] CMP_BASE  = CW'(NB_PIXEL - 2);
   localparam logic [CW-1:0] PASS_LAST = CW'(P);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CMP,
      BYPS,
      DONE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] pass, pass_n;
   logic          err_n;
   logic          dso_q, err_q;
   logic          dsi_c, byp_c, busy_c;

   // compare pass k lasts NB_PIXEL-1-k cycles, bypass lasts k+1
   logic cmp_last, byps_last, pass_last;
   assign cmp_last  = (cnt == (CMP_BASE - pass));
   assign byps_last = (cnt == pass);
   assign pass_last = (pass == PASS_LAST);

   // state, counters and registered pulses
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= '0;
         pass  <= '0;
         dso_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pass  <= pass_n;
         dso_q <= (state_n == DONE);
         err_q <= err_n;
      end
   end

   // next state, counter updates and protocol violations
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pass_n  = pass;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (DSI) begin
               state_n = LOAD;
               cnt_n   = ONE;
            end
         end
         LOAD: begin
            if (!DSI) begin
               state_n = IDLE;
               cnt_n   = '0;
               err_n   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_n = CMP;
               cnt_n   = '0;
               pass_n  = '0;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
         CMP: begin
            err_n = DSI;
            if (cmp_last) begin
               cnt_n   = '0;
               state_n = pass_last ? DONE : BYPS;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
         BYPS: begin
            err_n = DSI;
            if (byps_last) begin
               cnt_n   = '0;
               pass_n  = pass + ONE;
               state_n = CMP;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
         DONE: begin
            pass_n = '0;
            if (DSI) begin
               state_n = LOAD;
               cnt_n   = ONE;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            pass_n  = '0;
         end
      endcase
   end

   // datapath controls; first pixel is captured as DSI rises
   always_comb begin
      dsi_c  = 1'b0;
      byp_c  = 1'b0;
      busy_c = 1'b0;
      unique case (state)
         IDLE: begin
            dsi_c = DSI;
            byp_c = 1'b1;
         end
         LOAD: begin
            dsi_c  = DSI;
            byp_c  = 1'b1;
            busy_c = 1'b1;
         end
         CMP: begin
            busy_c = 1'b1;
         end
         BYPS: begin
            byp_c  = 1'b1;
            busy_c = 1'b1;
         end
         DONE: begin
            dsi_c = DSI;
            byp_c = 1'b1;
         end
         default: begin
            dsi_c = 1'b0;
         end
      endcase
   end

   // controls are forced low while reset is held
   assign MED_DSI = nRST & dsi_c;
   assign MED_BYP = nRST & byp_c;
   assign BUSY    = busy_c;
   assign DSO     = dso_q;
   assign ERR     = err_q;

endmodule

// File: doc/median_ctrl.md
# median_ctrl

Sequencing controller for the `MED` median datapath (9-register shift ring plus one compare-exchange cell). It counts a 9-pixel input burst and drives the datapath's `DSI` and `BYP` controls through the load and sort passes. It then flags the cycle in which the datapath output `DO` holds the median. Together with `MED` it forms the complete median filter; pixel data goes directly to `MED.DI` and does not pass through this block.

## Interface
- `NB_PIXEL`, default 9: window size; must be odd and ≥ 3. Define P = (NB_PIXEL-1)/2.
- `CLK` in 1: clock; all state changes on the rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `DSI` in 1: input strobe; high for NB_PIXEL consecutive cycles while pixels are presented on `MED.DI`.
- `MED_DSI` out 1: drives `MED.DSI`.
- `MED_BYP` out 1: drives `MED.BYP`.
- `DSO` out 1: one-cycle pulse; `MED.DO` equals the median in this cycle.
- `BUSY` out 1: frame in progress; high in LOAD/CMP/BYPS.
- `ERR` out 1: one-cycle pulse on protocol violation.

## Operation
- Datapath model: R8 = compare register, R7..R0 = queue with head R7 and tail R0. The queue shifts every clock.
  - Compare cycle (BYP=0, DSI=0): R8←max(R8,R7), R0←min.
  - Bypass cycle (BYP=1, DSI=0): R8←R7, R0←min.
- States: IDLE, LOAD, CMP, BYPS, DONE. Counters: `cnt` (0..NB_PIXEL-1) and `pass` (0..P).
- IDLE:
  - MED_DSI = DSI and MED_BYP = 1 (Mealy), so the first pixel is captured in the same cycle DSI rises.
  - DSI=1 → LOAD with cnt=1.
- LOAD:
  - MED_DSI=1 and MED_BYP=1.
  - DSI=1 and cnt=NB_PIXEL-1 → CMP with pass=0, cnt=0. Otherwise cnt++.
  - DSI=0 → abort: MED_DSI=0, next state IDLE, ERR pulse next cycle, no DSO.
- CMP (MED_BYP=0, MED_DSI=0): runs NB_PIXEL-1-pass cycles.
  - Then pass<P → BYPS.
  - Then pass=P → DONE.
- BYPS (MED_BYP=1, MED_DSI=0): runs pass+1 cycles, then pass++ → CMP.
- Pass k (k<P) therefore takes NB_PIXEL cycles: it discards the current maximum and advances one real value into R8. Stale entries stay in the tail slots that are excluded from later passes.
- After the final pass (NB_PIXEL-1-P compares), R8 holds the (P+1)-th largest value, i.e. the median.
- DONE:
  - DSO=1 for one cycle; MED_DSI = DSI, MED_BYP = 1.
  - DSI=1 → LOAD with cnt=1; this cycle counts as pixel 0 of the next frame, allowing back-to-back frames.
  - Otherwise → IDLE.
- DSI=1 in CMP/BYPS: ignored, ERR pulse next cycle, sequence unaffected.
- `cnt` and `pass` are sized $clog2(NB_PIXEL) bits; no wrap-around is reachable.

## Timing
- Cycle 0 = first cycle with DSI=1.
- Load occupies cycles 0..NB_PIXEL-1.
- Sort occupies the next P·NB_PIXEL + (NB_PIXEL-1-P) cycles.
- DSO is high in cycle NB_PIXEL·(P+2) - P - 1, which is cycle 49 for NB_PIXEL=9.
- BUSY is high in cycles 1..48 (NB_PIXEL=9).
- For NB_PIXEL=9, MED_BYP over cycles 9..48:
  - 8×0, 1×1
  - 7×0, 2×1
  - 6×0, 3×1
  - 5×0, 4×1
  - 4×0
- Reset values, also held while nRST=0: state IDLE, cnt=0, pass=0, DSO=0, BUSY=0, ERR=0, MED_DSI=0, MED_BYP=0.
- Reset mid-frame: the frame is dropped immediately with no DSO. The first DSI=1 after release starts a fresh frame.
- DSO and ERR are registered. MED_DSI and MED_BYP are combinational from state, counters and DSI.

## Test plan
Bench instantiates `median_ctrl` + `MED` with NB_PIXEL=9 and SIZE=8.
- Pixels 1..9 ascending from cycle 0 → DSO only in cycle 49, DO=5; BUSY high in cycles 1..48; MED_BYP pattern exactly as in Timing.
- Pixels {255,0,7,255,7,0,7,255,0} (duplicates, extremes) → DO=7 in DSO cycle; ERR never asserted.
- Frame A {9,8,...,1}, then frame B {200,10,30,50,90,70,110,130,150} with DSI rising in A's DSO cycle → DO=5 in cycle 49, DO=90 in cycle 98, no gap.
- DSI high 5 cycles then low → ERR pulse in cycle 6, BUSY low from cycle 6, no DSO. A following valid frame {3,1,4,1,5,9,2,6,5} → DO=4.
- nRST low during cycle 20 of a frame → DSO/BUSY/ERR/MED_DSI/MED_BYP go 0 asynchronously, no DSO ever for that frame. Next frame {2,2,2,2,2,2,2,2,2} → DO=2 at relative cycle 49.
- DSI pulsed in cycle 30 of frame {1..9} → ERR in cycle 31, DSO still in cycle 49 with DO=5.
